mem_wb_stage: RTL and testbench

Parametrised, handshaked pipeline register for the memory-to-writeback boundary. It carries one opaque payload word plus a separately gated control field (write enables, select bits) from the memory stage to the writeback stage. It adds what a bare pipeline register lacks: valid/ready backpressure, an optional 2-entry skid buffer, synchronous flush, bubble-safe control gating, and a saturating flush-drop counter.

---
 rtl/mem_wb_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush, bubble-gated control and drop counter.
module mem_wb_stage #(
  parameter int DATA_W = 36,
  parameter int CTRL_W = 5,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_drops
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CNT_W-1:0]  drops_q, drops_d;
  logic              in_fire, out_fire;
  logic              load_main, load_main_skid, load_skid;
  logic [1:0]        drop_n;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // State encoding doubles as the entry count; the head is valid in ONE and TWO.
  assign occupancy = state_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};

  // With the skid entry, ready depends only on registered state.
  assign in_ready = !rst && (SKID ? (state_q != S_TWO) : (!out_valid || out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d   = S_ONE;
            load_main = 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire && SKID) begin
            state_d   = S_TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d        = S_ONE;
            load_main      = 1'b1;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_data_d = load_main_skid ? skid_data_q : in_data;
    main_ctrl_d = load_main_skid ? skid_ctrl_q : in_ctrl;
  end

  // A beat consumed in the flush cycle is not a drop; an accepted beat is.
  always_comb begin
    drop_n  = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
    drops_d = flush ? sat_add(drops_q, drop_n) : drops_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      drops_q     <= '0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      drops_q <= drops_d;
      if (load_main) begin
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_q <= in_data;
      skid_ctrl_q <= in_ctrl;
    end
  end

  assign flush_drops = drops_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a skid instance, a saturating-counter
// instance and a single-register instance all share one stimulus stream.
module tb_mem_wb_stage;
  localparam int DW = 36;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [CW-1:0] a_out_ctrl;
  logic [1:0]    a_occ;
  logic [15:0]   a_drops;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [CW-1:0] s_out_ctrl;
  logic [1:0]    s_occ;
  logic [1:0]    s_drops;

  logic          z_in_ready, z_out_valid;
  logic [DW-1:0] z_out_data;
  logic [CW-1:0] z_out_ctrl;
  logic [1:0]    z_occ;
  logic [15:0]   z_drops;

  int checks;
  int errors;

  logic [DW+CW-1:0] qa[$];
  logic [DW+CW-1:0] qz[$];
  int               exp_drops_a;
  int               exp_drops_z;
  int               exp_drops_s;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .occupancy(a_occ), .flush_drops(a_drops));

  mem_wb_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .occupancy(s_occ), .flush_drops(s_drops));

  mem_wb_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(16)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
    .out_ctrl(z_out_ctrl), .occupancy(z_occ), .flush_drops(z_drops));

  // Called at a falling edge with inputs already driven; advances one cycle.
  task automatic step();
    logic             a_if, a_of, z_if, z_of;
    logic [DW+CW-1:0] e;
    #1;
    if (rst) begin
      qa.delete();
      qz.delete();
      exp_drops_a = 0;
      exp_drops_z = 0;
      exp_drops_s = 0;
    end else begin
      a_if = in_valid & a_in_ready;
      a_of = a_out_valid & out_ready;
      z_if = in_valid & z_in_ready;
      z_of = z_out_valid & out_ready;
      checks++;
      if (a_occ !== 2'(qa.size()) || a_out_valid !== (qa.size() != 0) || s_occ !== a_occ)
        begin errors++; $display("FAIL a_occ got %0d/%b want %0d", a_occ, a_out_valid, qa.size()); end
      checks++;
      if (z_occ !== 2'(qz.size()) || z_out_valid !== (qz.size() != 0))
        begin errors++; $display("FAIL z_occ got %0d/%b want %0d", z_occ, z_out_valid, qz.size()); end
      checks++;
      if (a_drops !== 16'(exp_drops_a) || z_drops !== 16'(exp_drops_z) || s_drops !== 2'(exp_drops_s))
        begin errors++; $display("FAIL drops got %0d/%0d/%0d want %0d/%0d/%0d", a_drops, z_drops, s_drops, exp_drops_a, exp_drops_z, exp_drops_s); end
      if (a_of) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL a_out_extra got %h want none", {a_out_ctrl, a_out_data});
        end else begin
          e = qa.pop_front();
          if ({a_out_ctrl, a_out_data} !== e) begin errors++; $display("FAIL a_out got %h want %h", {a_out_ctrl, a_out_data}, e); end
        end
      end
      if (z_of) begin
        checks++;
        if (qz.size() == 0) begin
          errors++; $display("FAIL z_out_extra got %h want none", {z_out_ctrl, z_out_data});
        end else begin
          e = qz.pop_front();
          if ({z_out_ctrl, z_out_data} !== e) begin errors++; $display("FAIL z_out got %h want %h", {z_out_ctrl, z_out_data}, e); end
        end
      end
      if (flush) begin
        exp_drops_a = exp_drops_a + qa.size() + int'(a_if);
        exp_drops_z = exp_drops_z + qz.size() + int'(z_if);
        exp_drops_s = exp_drops_s + qa.size() + int'(a_if);
        if (exp_drops_s > 3) exp_drops_s = 3;
        qa.delete();
        qz.delete();
      end else begin
        if (a_if) qa.push_back({in_ctrl, in_data});
        if (z_if) qz.push_back({in_ctrl, in_data});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 36'h5A5; in_ctrl = 5'h1F; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0 || z_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b/%b want 0", a_in_ready, z_in_ready); end
    checks++;
    if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_ctrl !== '0)
      begin errors++; $display("FAIL rst_out got %b %h %h want 0", a_out_valid, a_out_data, a_out_ctrl); end
    checks++;
    if (a_occ !== 2'd0 || a_drops !== 16'd0 || z_occ !== 2'd0) begin errors++; $display("FAIL rst_state got %0d %0d want 0", a_occ, a_drops); end
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || z_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b/%b want 1", a_in_ready, z_in_ready); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_ctrl = 5'h1F;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      if (i > 1) begin
        checks++;
        if (a_out_data !== DW'(i - 1) || a_occ !== 2'd1 || a_out_ctrl !== 5'h1F)
          begin errors++; $display("FAIL stream got %h occ %0d want %h occ 1", a_out_data, a_occ, i - 1); end
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (a_out_data !== DW'(8) || a_occ !== 2'd1) begin errors++; $display("FAIL stream_last got %h want 8", a_out_data); end
    step();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int max_occ = 0;
    in_ctrl = 5'h03;
    for (int c = 0; c < 9; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      in_valid  = (sent < 4);
      in_data   = DW'(36'h10 + sent);
      #1;
      if (int'(a_occ) > max_occ) max_occ = int'(a_occ);
      if (c >= 2 && c <= 4) begin
        checks++;
        if (a_in_ready !== 1'b0 || a_occ !== 2'd2) begin errors++; $display("FAIL stall c%0d got ready %b occ %0d want 0/2", c, a_in_ready, a_occ); end
      end
      if (in_valid && a_in_ready) sent++;
      step();
    end
    checks++;
    if (max_occ != 2 || sent != 4) begin errors++; $display("FAIL bp_summary got occ %0d sent %0d want 2/4", max_occ, sent); end
  endtask

  task automatic test_flush();
    logic [15:0] d0;
    out_ready = 1'b0; in_ctrl = 5'h03;
    in_valid = 1'b1; in_data = 36'h100; step();
    in_data = 36'h101; step();
    in_data = 36'h102; flush = 1'b1; d0 = a_drops;
    checks++;
    if (a_occ !== 2'd2) begin errors++; $display("FAIL flush_pre got occ %0d want 2", a_occ); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_ctrl !== '0 || a_occ !== 2'd0 || a_drops - d0 !== 16'd2)
      begin errors++; $display("FAIL flush_two got v%b c%h occ %0d inc %0d want 0/0/0/2", a_out_valid, a_out_ctrl, a_occ, a_drops - d0); end
    checks++;
    if (a_out_data !== 36'h100) begin errors++; $display("FAIL flush_payload got %h want 100", a_out_data); end
    step();
    in_valid = 1'b1; in_data = 36'h103; step();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; d0 = a_drops; step();
    flush = 1'b0;
    checks++;
    if (a_drops !== d0 || a_occ !== 2'd0) begin errors++; $display("FAIL flush_outfire got inc %0d occ %0d want 0/0", a_drops - d0, a_occ); end
    in_valid = 1'b1; in_data = 36'h104; step();
    in_data = 36'h105; out_ready = 1'b0; flush = 1'b1; d0 = a_drops; step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (a_drops - d0 !== 16'd2 || a_out_data !== 36'h104)
      begin errors++; $display("FAIL flush_incoming got inc %0d data %h want 2/104", a_drops - d0, a_out_data); end
    step();
  endtask

  task automatic test_bubble();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 36'hABC; in_ctrl = 5'h1F;
    step();
    in_valid = 1'b0; in_ctrl = 5'h00;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_ctrl !== 5'h1F) begin errors++; $display("FAIL bubble_live got %b %h want 1 1f", a_out_valid, a_out_ctrl); end
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_out_valid !== 1'b0 || a_out_ctrl !== 5'h00 || a_out_data !== 36'hABC || z_out_ctrl !== 5'h00 || z_out_data !== 36'hABC)
        begin errors++; $display("FAIL bubble_gate got %b %h %h want 0 0 abc", a_out_valid, a_out_ctrl, a_out_data); end
      step();
    end
  endtask

  task automatic test_saturation();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (s_drops !== 2'd0) begin errors++; $display("FAIL sat_start got %0d want 0", s_drops); end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = DW'(36'h200 + k); in_ctrl = 5'h07;
      step();
      in_data = DW'(36'h300 + k);
      step();
      in_valid = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (s_drops !== ((k == 0) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL sat_flush%0d got %0d want %0d", k, s_drops, (k == 0) ? 2 : 3); end
    end
    step();
    checks++;
    if (s_drops !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", s_drops); end
    rst = 1'b1;
    step();
    checks++;
    if (s_drops !== 2'd0 || a_drops !== 16'd0) begin errors++; $display("FAIL sat_rst got %0d/%0d want 0", s_drops, a_drops); end
    rst = 1'b0;
  endtask

  task automatic test_random_skid0();
    int bad = 0;
    flush = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {4'($urandom), $urandom};
      in_ctrl   = 5'($urandom);
      #1;
      checks++;
      if (z_occ > 2'd1 || z_in_ready !== (!z_out_valid || out_ready)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL z_ready c%0d got rdy %b occ %0d want %b", c, z_in_ready, z_occ, !z_out_valid || out_ready);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (qa.size() != 0 || qz.size() != 0) begin errors++; $display("FAIL drain got %0d/%0d want 0", qa.size(), qz.size()); end
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_drops_a = 0; exp_drops_z = 0; exp_drops_s = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_random_skid0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
